// File: rtl/airi5c_dm_regaccess_pkg.sv
// Shared encodings for the debug-module abstract-command (Access Register) engine:
// cmderr codes, command-word field positions, register-number windows and FSM states.
package airi5c_dm_regaccess_pkg;

    localparam logic [2:0] CMDERR_NONE       = 3'd0;
    localparam logic [2:0] CMDERR_BUSY       = 3'd1;
    localparam logic [2:0] CMDERR_NOTSUP     = 3'd2;
    localparam logic [2:0] CMDERR_EXC        = 3'd3;
    localparam logic [2:0] CMDERR_HALTRESUME = 3'd4;

    localparam logic [7:0]  CMDTYPE_ACCESS_REG = 8'd0;
    localparam logic [2:0]  AARSIZE_32         = 3'd2;
    localparam logic [15:0] REGNO_GPR_BASE     = 16'h1000;
    localparam logic [15:0] REGNO_FPR_BASE     = 16'h1020;
    localparam logic [15:0] REGNO_FPR_LAST     = 16'h103F;

    localparam int CMD_TYPE_LSB     = 24;
    localparam int CMD_AARSIZE_LSB  = 20;
    localparam int CMD_POSTINC_BIT  = 19;
    localparam int CMD_TRANSFER_BIT = 17;
    localparam int CMD_WRITE_BIT    = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // regno occupies the low half-word and wraps within it; upper fields are preserved.
    function automatic logic [31:0] cmd_postinc(input logic [31:0] cmd);
        return {cmd[31:16], cmd[15:0] + 16'd1};
    endfunction

endpackage

// File: rtl/airi5c_dm_regaccess.sv
// Abstract "Access Register" command engine: decodes the latched command, drives the
// register-file debug port for one cycle and reports results/errors back to the DMI block.
module airi5c_dm_regaccess
    import airi5c_dm_regaccess_pkg::*;
#(
    parameter int XPR_LEN = 32,
    parameter int NUM_GPR = 32,
    parameter bit HAS_FPU = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               cmd_valid_i,
    input  logic [31:0]        cmd_i,
    input  logic [XPR_LEN-1:0] data0_i,
    output logic [XPR_LEN-1:0] data0_o,
    output logic               data0_we_o,
    output logic [31:0]        cmd_upd_o,
    output logic               cmd_upd_we_o,
    output logic               busy_o,
    output logic [2:0]         cmderr_o,
    input  logic [2:0]         cmderr_clr_i,
    input  logic               halted_i,
    output logic [4:0]         dm_wara_o,
    output logic [XPR_LEN-1:0] dm_wd_o,
    output logic               dm_wen_o,
    output logic               dm_sel_fpu_reg_o,
    input  logic [XPR_LEN-1:0] dm_rd_i
);

    localparam logic [15:0] REGNO_GPR_END = 16'(REGNO_GPR_BASE + NUM_GPR);

    state_e             state_q, state_d;
    logic [31:0]        cmd_q, cmd_d;
    logic [XPR_LEN-1:0] arg_q, arg_d;
    logic [XPR_LEN-1:0] data0_q, data0_d;
    logic               data0_we_q, data0_we_d;
    logic [31:0]        upd_q, upd_d;
    logic               upd_we_q, upd_we_d;
    logic               busy_q, busy_d;
    logic [2:0]         cmderr_q, cmderr_d;
    logic [4:0]         wara_q, wara_d;
    logic [XPR_LEN-1:0] wd_q, wd_d;
    logic               wen_q, wen_d;
    logic               sel_q, sel_d;

    logic [15:0] regno;
    logic [7:0]  cmdtype;
    logic [2:0]  aarsize;
    logic        postinc, transfer, write;
    logic        gpr_hit, fpr_hit, is_x0;
    logic [2:0]  dec_err, err_set;

    assign regno    = cmd_q[15:0];
    assign cmdtype  = cmd_q[CMD_TYPE_LSB +: 8];
    assign aarsize  = cmd_q[CMD_AARSIZE_LSB +: 3];
    assign postinc  = cmd_q[CMD_POSTINC_BIT];
    assign transfer = cmd_q[CMD_TRANSFER_BIT];
    assign write    = cmd_q[CMD_WRITE_BIT];
    assign gpr_hit  = (regno >= REGNO_GPR_BASE) && (regno < REGNO_GPR_END);
    assign fpr_hit  = HAS_FPU && (regno >= REGNO_FPR_BASE) && (regno <= REGNO_FPR_LAST);
    assign is_x0    = (regno == REGNO_GPR_BASE);

    always_comb begin
        dec_err = CMDERR_NONE;
        if (!halted_i) begin
            dec_err = CMDERR_HALTRESUME;
        end else if ((cmdtype != CMDTYPE_ACCESS_REG) || (transfer && (aarsize != AARSIZE_32))) begin
            dec_err = CMDERR_NOTSUP;
        end else if (transfer && !(gpr_hit || fpr_hit)) begin
            dec_err = CMDERR_EXC;
        end
    end

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        arg_d      = arg_q;
        data0_d    = data0_q;
        data0_we_d = 1'b0;
        upd_d      = upd_q;
        upd_we_d   = 1'b0;
        busy_d     = busy_q;
        wara_d     = wara_q;
        sel_d      = sel_q;
        wd_d       = '0;
        wen_d      = 1'b0;
        err_set    = CMDERR_NONE;

        // A new command while one is running only flags the collision.
        if (cmd_valid_i && busy_q) begin
            err_set = CMDERR_BUSY;
        end

        case (state_q)
            ST_IDLE: begin
                wara_d = '0;
                sel_d  = 1'b0;
                if (cmd_valid_i && (cmderr_q == CMDERR_NONE)) begin
                    cmd_d   = cmd_i;
                    arg_d   = data0_i;
                    busy_d  = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (dec_err != CMDERR_NONE) begin
                    err_set = dec_err;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (transfer) begin
                    wara_d  = regno[4:0];
                    sel_d   = regno[5];
                    wd_d    = arg_q;
                    wen_d   = write && !is_x0;
                    state_d = ST_ACCESS;
                end else begin
                    upd_we_d = postinc;
                    upd_d    = postinc ? cmd_postinc(cmd_q) : upd_q;
                    state_d  = ST_DONE;
                end
            end
            ST_ACCESS: begin
                if (!write) begin
                    data0_d    = is_x0 ? '0 : dm_rd_i;
                    data0_we_d = 1'b1;
                end
                upd_we_d = postinc;
                upd_d    = postinc ? cmd_postinc(cmd_q) : upd_q;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                wara_d  = '0;
                sel_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        cmderr_d = (err_set != CMDERR_NONE) ? err_set : (cmderr_q & ~cmderr_clr_i);
    end

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            data0_q    <= '0;
            data0_we_q <= 1'b0;
            upd_q      <= '0;
            upd_we_q   <= 1'b0;
            busy_q     <= 1'b0;
            cmderr_q   <= CMDERR_NONE;
            wara_q     <= '0;
            wd_q       <= '0;
            wen_q      <= 1'b0;
            sel_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            data0_q    <= data0_d;
            data0_we_q <= data0_we_d;
            upd_q      <= upd_d;
            upd_we_q   <= upd_we_d;
            busy_q     <= busy_d;
            cmderr_q   <= cmderr_d;
            wara_q     <= wara_d;
            wd_q       <= wd_d;
            wen_q      <= wen_d;
            sel_q      <= sel_d;
        end
    end

    // Latched command/argument: only read after being loaded in IDLE
    always_ff @(posedge clk_i) begin
        cmd_q <= cmd_d;
        arg_q <= arg_d;
    end

    assign data0_o          = data0_q;
    assign data0_we_o       = data0_we_q;
    assign cmd_upd_o        = upd_q;
    assign cmd_upd_we_o     = upd_we_q;
    assign busy_o           = busy_q;
    assign cmderr_o         = cmderr_q;
    assign dm_wara_o        = wara_q;
    assign dm_wd_o          = wd_q;
    assign dm_wen_o         = wen_q;
    assign dm_sel_fpu_reg_o = sel_q;

endmodule

// File: tb/tb_airi5c_dm_regaccess.sv
// Bench for airi5c_dm_regaccess: two instances (full build, and E build without FPU)
// share stimulus; a per-command transaction model feeds a scoreboard checked at busy fall.
module tb_airi5c_dm_regaccess;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [31:0] cmd = '0;
    logic [31:0] data0_in = '0;
    logic [2:0]  clr = '0;
    logic        halted = 1'b1;

    logic [31:0] dm_rd    [2];
    logic [31:0] data0_w  [2];
    logic        data0_we_w [2];
    logic [31:0] upd_w    [2];
    logic        upd_we_w [2];
    logic        busy_w   [2];
    logic [2:0]  cmderr_w [2];
    logic [4:0]  wara_w   [2];
    logic [31:0] wd_w     [2];
    logic        wen_w    [2];
    logic        sel_w    [2];

    logic [31:0] rf [64];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        assign dm_rd[g] = rf[{sel_w[g], wara_w[g]}];
        airi5c_dm_regaccess #(
            .XPR_LEN(32),
            .NUM_GPR(g == 0 ? 32 : 16),
            .HAS_FPU(g == 0)
        ) u_dut (
            .clk_i(clk),
            .rst_ni(rst_n),
            .cmd_valid_i(cmd_valid),
            .cmd_i(cmd),
            .data0_i(data0_in),
            .data0_o(data0_w[g]),
            .data0_we_o(data0_we_w[g]),
            .cmd_upd_o(upd_w[g]),
            .cmd_upd_we_o(upd_we_w[g]),
            .busy_o(busy_w[g]),
            .cmderr_o(cmderr_w[g]),
            .cmderr_clr_i(clr),
            .halted_i(halted),
            .dm_wara_o(wara_w[g]),
            .dm_wd_o(wd_w[g]),
            .dm_wen_o(wen_w[g]),
            .dm_sel_fpu_reg_o(sel_w[g]),
            .dm_rd_i(dm_rd[g])
        );
    end

    typedef struct {
        int          busy_len;
        logic [2:0]  err;
        int          wen_cnt;
        int          rd_cnt;
        int          upd_cnt;
        logic [5:0]  acc;
        logic [31:0] wd;
        logic [31:0] rd;
        logic [31:0] upd;
    } rec_t;

    rec_t q0[$];
    rec_t q1[$];

    int checks = 0;
    int errors = 0;
    int zero_req = 0, zero_seen = 0;
    int end_req = 0, end_seen = 0;
    logic [2:0] errs_m [2] = '{3'd0, 3'd0};

    // ---------------- reference model ----------------
    function automatic rec_t blank_rec();
        rec_t r;
        r.busy_len = 0; r.err = 3'd0; r.wen_cnt = 0; r.rd_cnt = 0; r.upd_cnt = 0;
        r.acc = '0; r.wd = '0; r.rd = '0; r.upd = '0;
        return r;
    endfunction

    function automatic logic [2:0] model_err(int k, logic [31:0] c, logic h);
        int  rn;
        int  ngpr;
        bit  legal;
        rn    = int'(c[15:0]);
        ngpr  = (k == 0) ? 32 : 16;
        legal = (rn >= 'h1000 && rn < 'h1000 + ngpr) || (k == 0 && rn >= 'h1020 && rn <= 'h103F);
        if (!h) return 3'd4;
        if (c[31:24] != 8'd0 || (c[17] && c[22:20] != 3'd2)) return 3'd2;
        if (c[17] && !legal) return 3'd3;
        return 3'd0;
    endfunction

    task automatic predict(input logic [31:0] c, input logic [31:0] d, input logic h, input bit dup);
        rec_t r;
        logic [2:0] e;
        bit ok;
        for (int k = 0; k < 2; k++) begin
            if (errs_m[k] == 3'd0) begin
                e  = model_err(k, c, h);
                ok = (e == 3'd0);
                r  = blank_rec();
                r.err      = ok ? (dup ? 3'd1 : 3'd0) : e;
                r.busy_len = ok ? (c[17] ? 3 : 2) : 1;
                r.wen_cnt  = (ok && c[17] && c[16] && c[15:0] != 16'h1000) ? 1 : 0;
                r.rd_cnt   = (ok && c[17] && !c[16]) ? 1 : 0;
                r.upd_cnt  = (ok && c[19]) ? 1 : 0;
                r.acc      = c[5:0];
                r.wd       = d;
                r.rd       = (c[15:0] == 16'h1000) ? 32'd0 : rf[c[5:0]];
                r.upd      = {c[31:16], c[15:0] + 16'd1};
                errs_m[k]  = r.err;
                if (k == 0) q0.push_back(r); else q1.push_back(r);
            end
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    int          obs_busy [2] = '{0, 0};
    int          obs_wen  [2] = '{0, 0};
    int          obs_rd   [2] = '{0, 0};
    int          obs_upd  [2] = '{0, 0};
    int          idle_cyc [2] = '{0, 0};
    logic [5:0]  obs_acc  [2];
    logic [31:0] obs_wd   [2];
    logic [31:0] obs_rdv  [2];
    logic [31:0] obs_updv [2];
    bit          prev_busy [2] = '{1'b0, 1'b0};

    task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d got %0h expected %0h", nm, k, act, exp);
        end
    endtask

    always @(negedge clk) begin
        rec_t r;
        int   qs;
        for (int k = 0; k < 2; k++) begin
            if (busy_w[k] === 1'b1) obs_busy[k]++;
            if (wen_w[k] === 1'b1) begin
                obs_wen[k]++; obs_acc[k] = {sel_w[k], wara_w[k]}; obs_wd[k] = wd_w[k];
            end
            if (data0_we_w[k] === 1'b1) begin
                obs_rd[k]++; obs_acc[k] = {sel_w[k], wara_w[k]}; obs_rdv[k] = data0_w[k];
            end
            if (upd_we_w[k] === 1'b1) begin
                obs_upd[k]++; obs_updv[k] = upd_w[k];
            end
            qs = (k == 0) ? q0.size() : q1.size();
            if (prev_busy[k] && busy_w[k] !== 1'b1) begin
                if (qs == 0) begin
                    chk("unexpected_cmd", k, 64'd1, 64'd0);
                end else begin
                    r = (k == 0) ? q0.pop_front() : q1.pop_front();
                    chk("busy_len", k, 64'(obs_busy[k]), 64'(r.busy_len));
                    chk("cmderr", k, 64'(cmderr_w[k]), 64'(r.err));
                    chk("wen_cnt", k, 64'(obs_wen[k]), 64'(r.wen_cnt));
                    chk("rd_cnt", k, 64'(obs_rd[k]), 64'(r.rd_cnt));
                    chk("upd_cnt", k, 64'(obs_upd[k]), 64'(r.upd_cnt));
                    chk("idle_port", k, 64'({sel_w[k], wara_w[k], wd_w[k]}), 64'd0);
                    if (r.wen_cnt > 0 && obs_wen[k] > 0) begin
                        chk("wr_addr", k, 64'(obs_acc[k]), 64'(r.acc));
                        chk("wr_data", k, 64'(obs_wd[k]), 64'(r.wd));
                    end
                    if (r.rd_cnt > 0 && obs_rd[k] > 0) begin
                        chk("rd_addr", k, 64'(obs_acc[k]), 64'(r.acc));
                        chk("rd_data", k, 64'(obs_rdv[k]), 64'(r.rd));
                    end
                    if (r.upd_cnt > 0 && obs_upd[k] > 0) chk("cmd_upd", k, 64'(obs_updv[k]), 64'(r.upd));
                end
                obs_busy[k] = 0; obs_wen[k] = 0; obs_rd[k] = 0; obs_upd[k] = 0;
            end
            // Expected command that never shows busy
            if (qs != 0 && busy_w[k] !== 1'b1 && !prev_busy[k]) idle_cyc[k]++;
            else idle_cyc[k] = 0;
            if (idle_cyc[k] > 10) begin
                chk("cmd_timeout", k, 64'd1, 64'd0);
                if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                idle_cyc[k] = 0;
            end
            prev_busy[k] = (busy_w[k] === 1'b1);
        end
        if (zero_req != zero_seen) begin
            zero_seen = zero_req;
            for (int k = 0; k < 2; k++) begin
                chk("rst_ctl", k, 64'({busy_w[k], cmderr_w[k], wen_w[k], data0_we_w[k],
                                       upd_we_w[k], sel_w[k], wara_w[k]}), 64'd0);
                chk("rst_wd", k, 64'(wd_w[k]), 64'd0);
                chk("rst_data0", k, 64'(data0_w[k]), 64'd0);
                chk("rst_upd", k, 64'(upd_w[k]), 64'd0);
            end
        end
        if (end_req != end_seen) begin
            end_seen = end_req;
            chk("drained", 0, 64'(q0.size()), 64'd0);
            chk("drained", 1, 64'(q1.size()), 64'd0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_done();
        for (int i = 0; i < 40; i++) begin
            if (q0.size() == 0 && q1.size() == 0) break;
            @(posedge clk);
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic run_cmd(input logic [31:0] c, input logic [31:0] d, input logic h, input bit dup);
        @(posedge clk); #1;
        predict(c, d, h, dup);
        cmd = c; data0_in = d; halted = h; cmd_valid = 1'b1;
        @(posedge clk); #1;
        if (dup) begin
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        cmd = $urandom; data0_in = $urandom;
        wait_done();
    endtask

    task automatic clear_err(input logic [2:0] mask);
        @(posedge clk); #1;
        clr = mask;
        for (int k = 0; k < 2; k++) errs_m[k] = errs_m[k] & ~mask;
        @(posedge clk); #1;
        clr = 3'd0;
    endtask

    task automatic abort_read();
        rec_t r;
        @(posedge clk); #1;
        r = blank_rec();
        r.busy_len = 2;
        q0.push_back(r); q1.push_back(r);
        cmd = 32'h0022_1001; data0_in = $urandom; halted = 1'b1; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        errs_m[0] = 3'd0; errs_m[1] = 3'd0;
        zero_req++;
        wait_done();
    endtask

    function automatic logic [15:0] pick_regno();
        case ($urandom_range(0, 7))
            0, 1, 2: return 16'h1000 + 16'($urandom_range(0, 31));
            3, 4:    return 16'h1020 + 16'($urandom_range(0, 31));
            5:       return 16'h1000;
            6: begin
                case ($urandom_range(0, 2))
                    0: return 16'h103F;
                    1: return 16'h1040;
                    default: return 16'h0FFF;
                endcase
            end
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] c;
        logic        h;
        bit          dup;
        for (int i = 0; i < 64; i++) rf[i] = $urandom;
        rf[1] = 32'h1234_5678;

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        zero_req++;
        repeat (2) @(posedge clk);

        run_cmd(32'h0023_1005, 32'hCAFE_F00D, 1'b1, 1'b0);   // write x5
        run_cmd(32'h0022_1001, $urandom, 1'b1, 1'b0);        // read x1
        run_cmd(32'h002A_1022, $urandom, 1'b1, 1'b0);        // read f2, postinc
        clear_err(3'b111);
        run_cmd(32'h0023_1005, $urandom, 1'b0, 1'b0);        // not halted
        run_cmd(32'h0023_1006, $urandom, 1'b1, 1'b0);        // ignored while cmderr set
        repeat (6) @(posedge clk);
        clear_err(3'b111);
        run_cmd(32'h0022_1003, $urandom, 1'b1, 1'b1);        // collision while busy
        clear_err(3'b111);
        run_cmd(32'h0023_1000, $urandom, 1'b1, 1'b0);        // write x0
        run_cmd(32'h0022_1000, $urandom, 1'b1, 1'b0);        // read x0
        run_cmd(32'h0122_1001, $urandom, 1'b1, 1'b0);        // cmdtype 1
        clear_err(3'b111);
        run_cmd(32'h0032_1001, $urandom, 1'b1, 1'b0);        // aarsize 3
        clear_err(3'b111);
        run_cmd(32'h0028_FFFF, $urandom, 1'b1, 1'b0);        // no transfer, postinc wrap
        run_cmd(32'h0022_1040, $urandom, 1'b1, 1'b0);        // past FPR window
        clear_err(3'b111);
        run_cmd(32'h0022_1010, $urandom, 1'b1, 1'b0);        // x16: E build rejects
        clear_err(3'b111);
        abort_read();

        for (int n = 0; n < 70; n++) begin
            c[31:24] = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
            c[23]    = 1'($urandom);
            c[22:20] = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'd2;
            c[19]    = 1'($urandom);
            c[18]    = 1'($urandom);
            c[17]    = ($urandom_range(0, 7) != 0);
            c[16]    = 1'($urandom);
            c[15:0]  = pick_regno();
            h        = ($urandom_range(0, 15) != 0);
            dup      = (errs_m[0] == 3'd0) && (errs_m[1] == 3'd0) && (model_err(0, c, h) == 3'd0) &&
                       (model_err(1, c, h) == 3'd0) && ($urandom_range(0, 7) == 0);
            run_cmd(c, $urandom, h, dup);
            if ((errs_m[0] != 3'd0 || errs_m[1] != 3'd0) && $urandom_range(0, 3) != 0)
                clear_err(($urandom_range(0, 3) != 0) ? 3'b111 : 3'($urandom));
        end

        wait_done();
        end_req++;
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
